writeback: RTL and testbench

WRITEBACK -- requirements
Module: writeback

---
 rtl/writeback.sv | 189 ++++++++++++++++++
 tb/tb_writeback.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback.sv
// Writeback stage: retires ALU results, jump links and loads into the register file.
// Optional load-wait timeout with sticky error flag is compiled in under WB_LD_TIMEOUT_EN.

package wb_pkg;
  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LW  = 3'd2;
  localparam logic [2:0] LD_LBU = 3'd4;
  localparam logic [2:0] LD_LHU = 3'd5;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd_ind;
    logic [31:0] reg_dat;
    logic        jmp_take;
    logic [31:0] jmp_addr;
    logic        ld_en;
    logic [2:0]  ld_spec;
    logic [1:0]  ld_off;
  } e_w_WI;

  typedef struct packed {
    logic        flush;
    logic [31:0] redir_addr;
  } w_e_WI;
endpackage

// state   | meaning
// IDLE    | ready to accept an execute result
// LD_WAIT | load issued, waiting for mem_rvalid; upstream held
// FLUSH   | taken jump, flush held for FLUSH_CYC cycles, e_in discarded
module writeback
  import wb_pkg::*;
#(
  parameter int FLUSH_CYC   = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  e_w_WI       e_in,
  input  logic        stall_in,
  input  logic [31:0] mem_rdat,
  input  logic        mem_rvalid,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdat,
  output w_e_WI       w_out,
  output logic        stall_out,
  output logic        ld_err
);

  if (FLUSH_CYC < 1 || FLUSH_CYC > 15) begin : g_bad_flush
    $error("FLUSH_CYC out of range 1..15");
  end
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_tmo
    $error("TIMEOUT_CYC out of range 2..255");
  end

  typedef enum logic [1:0] {IDLE, LD_WAIT, FLUSH} state_e;

  state_e      state_q;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdat_q;
  logic        flush_q;
  logic [31:0] redir_q;
  logic [3:0]  flush_cnt_q;
  logic [4:0]  ld_rd_q;
  logic [2:0]  ld_spec_q;
  logic [1:0]  ld_off_q;
  logic [31:0] ld_res_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        accept;

`ifdef WB_LD_TIMEOUT_EN
  logic [7:0]  tmo_cnt_q;
  logic        ld_err_q;
`endif

  assign accept = (state_q == IDLE) && e_in.valid && !stall_in;

  always_comb begin
    byte_sel = mem_rdat[{ld_off_q, 3'b000} +: 8];
    half_sel = ld_off_q[1] ? mem_rdat[31:16] : mem_rdat[15:0];
    case (ld_spec_q)
      LD_LB:   ld_res_d = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  ld_res_d = {24'h0, byte_sel};
      LD_LH:   ld_res_d = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  ld_res_d = {16'h0, half_sel};
      default: ld_res_d = mem_rdat;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdat_q   <= '0;
      flush_q     <= 1'b0;
      redir_q     <= '0;
      flush_cnt_q <= '0;
      ld_rd_q     <= '0;
      ld_spec_q   <= '0;
      ld_off_q    <= '0;
`ifdef WB_LD_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      ld_err_q    <= 1'b0;
`endif
    end else begin
      // Write port is a one-cycle pulse; address/data read as zero otherwise.
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdat_q  <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (e_in.jmp_take) begin
              if (e_in.rd_ind != 5'd0) begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= e_in.rd_ind;
                rf_wdat_q  <= e_in.reg_dat;
              end
              flush_q     <= 1'b1;
              redir_q     <= e_in.jmp_addr;
              flush_cnt_q <= 4'(FLUSH_CYC - 1);
              state_q     <= FLUSH;
            end else if (e_in.ld_en) begin
              ld_rd_q   <= e_in.rd_ind;
              ld_spec_q <= e_in.ld_spec;
              ld_off_q  <= e_in.ld_off;
`ifdef WB_LD_TIMEOUT_EN
              tmo_cnt_q <= 8'(TIMEOUT_CYC - 1);
`endif
              state_q   <= LD_WAIT;
            end else if (e_in.rd_ind != 5'd0) begin
              rf_we_q    <= 1'b1;
              rf_waddr_q <= e_in.rd_ind;
              rf_wdat_q  <= e_in.reg_dat;
            end
          end
        end
        LD_WAIT: begin
          if (mem_rvalid) begin
            if (ld_rd_q != 5'd0) begin
              rf_we_q    <= 1'b1;
              rf_waddr_q <= ld_rd_q;
              rf_wdat_q  <= ld_res_d;
            end
            state_q <= IDLE;
          end
`ifdef WB_LD_TIMEOUT_EN
          else if (tmo_cnt_q == 8'd0) begin
            ld_err_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q - 8'd1;
          end
`endif
        end
        FLUSH: begin
          if (flush_cnt_q == 4'd0) begin
            flush_q <= 1'b0;
            redir_q <= '0;
            state_q <= IDLE;
          end else begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rf_we            = rf_we_q;
  assign rf_waddr         = rf_waddr_q;
  assign rf_wdat          = rf_wdat_q;
  assign w_out.flush      = flush_q;
  assign w_out.redir_addr = redir_q;
  assign stall_out        = (state_q == LD_WAIT);

`ifdef WB_LD_TIMEOUT_EN
  assign ld_err = ld_err_q;
`else
  assign ld_err = 1'b0;
`endif

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: scoreboard of expected register writes plus
// directed checks of stall, flush, reset and timeout behaviour.
module tb_writeback;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  e_w_WI       e_in;
  logic        stall_in;
  logic [31:0] mem_rdat;
  logic        mem_rvalid;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdat;
  w_e_WI       w_out;
  logic        stall_out;
  logic        ld_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [36:0] sb_q[$];

  writeback #(.FLUSH_CYC(2), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .e_in(e_in), .stall_in(stall_in),
    .mem_rdat(mem_rdat), .mem_rvalid(mem_rvalid),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdat(rf_wdat),
    .w_out(w_out), .stall_out(stall_out), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rf_we) begin
        chk("sb_wr_expected", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          logic [36:0] e;
          e = sb_q.pop_front();
          chk("sb_wr_addr", {27'b0, rf_waddr}, {27'b0, e[36:32]});
          chk("sb_wr_data", rf_wdat, e[31:0]);
        end
      end else begin
        chk("wr_idle_zero", {27'b0, rf_waddr} | rf_wdat, 32'd0);
      end
    end
  end

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] dat);
    e_in = '0;
    e_in.valid = 1'b1;
    e_in.rd_ind = rd;
    e_in.reg_dat = dat;
    if (rd != 5'd0) sb_q.push_back({rd, dat});
    step();
    e_in = '0;
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [2:0] spec, input logic [1:0] off,
                         input logic [31:0] rdat, input logic [31:0] exp, input int waits);
    int cnt;
    e_in = '0;
    e_in.valid = 1'b1;
    e_in.ld_en = 1'b1;
    e_in.rd_ind = rd;
    e_in.ld_spec = spec;
    e_in.ld_off = off;
    e_in.reg_dat = 32'hDEAD_BEEF;
    if (rd != 5'd0) sb_q.push_back({rd, exp});
    step();
    e_in = '0;
    cnt = 0;
    for (int i = 0; i < waits + 4; i++) begin
      if (stall_out) cnt++;
      mem_rvalid = (i == waits);
      mem_rdat = (i == waits) ? rdat : 32'h5A5A_5A5A;
      step();
    end
    mem_rvalid = 1'b0;
    chk("ld_stall_cycles", 32'(cnt), 32'(waits + 1));
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    e_in = '0;
    stall_in = 1'b0;
    mem_rdat = '0;
    mem_rvalid = 1'b0;
    step();
    step();
    chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
    chk("rst_rf_waddr", {27'b0, rf_waddr}, 32'd0);
    chk("rst_rf_wdat", rf_wdat, 32'd0);
    chk("rst_flush", {31'b0, w_out.flush}, 32'd0);
    chk("rst_redir", w_out.redir_addr, 32'd0);
    chk("rst_stall", {31'b0, stall_out}, 32'd0);
    chk("rst_ld_err", {31'b0, ld_err}, 32'd0);
    rst_n = 1'b1;
    step();

    // ALU results
    drive_alu(5'd5, 32'h0000_1234);
    chk("alu_we", {31'b0, rf_we}, 32'd1);
    chk("alu_waddr", {27'b0, rf_waddr}, 32'd5);
    chk("alu_wdat", rf_wdat, 32'h0000_1234);
    drive_alu(5'd0, 32'h0000_5555);
    chk("alu_x0_no_we", {31'b0, rf_we}, 32'd0);
    drive_alu(5'd31, 32'hFFFF_0001);
    step();

    // Loads: rd, spec, off, mem word, expected, wait cycles
    do_load(5'd7,  LD_LB,  2'd2, 32'h0080_0000, 32'hFFFF_FF80, 3);
    do_load(5'd8,  LD_LBU, 2'd2, 32'h0080_0000, 32'h0000_0080, 3);
    do_load(5'd9,  LD_LB,  2'd3, 32'h7F00_00FF, 32'h0000_007F, 0);
    do_load(5'd10, LD_LH,  2'd2, 32'h8001_1234, 32'hFFFF_8001, 1);
    do_load(5'd11, LD_LHU, 2'd3, 32'h8001_1234, 32'h0000_8001, 2);
    do_load(5'd12, LD_LH,  2'd1, 32'h8001_1234, 32'h0000_1234, 0);
    do_load(5'd13, LD_LW,  2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D, 5);
    do_load(5'd0,  LD_LW,  2'd0, 32'h1111_2222, 32'h0, 1);

    // mem_rvalid in IDLE must not write anything
    mem_rvalid = 1'b1;
    mem_rdat = 32'h1234_5678;
    step();
    mem_rvalid = 1'b0;
    chk("idle_rvalid_stall", {31'b0, stall_out}, 32'd0);

    // Jump with ld_en also set: jump wins, link written, flush 2 cycles
    e_in = '0;
    e_in.valid = 1'b1;
    e_in.jmp_take = 1'b1;
    e_in.ld_en = 1'b1;
    e_in.rd_ind = 5'd1;
    e_in.reg_dat = 32'h0000_0104;
    e_in.jmp_addr = 32'h0000_0200;
    sb_q.push_back({5'd1, 32'h0000_0104});
    step();
    chk("jmp_we", {31'b0, rf_we}, 32'd1);
    chk("jmp_no_stall", {31'b0, stall_out}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (w_out.flush) begin
        cnt++;
        chk("jmp_redir", w_out.redir_addr, 32'h0000_0200);
      end
      e_in = '0;
      if (i < 2) begin
        e_in.valid = 1'b1;
        e_in.rd_ind = 5'd9;
        e_in.reg_dat = 32'hBAD0_BAD0;
      end
      step();
    end
    chk("jmp_flush_cycles", 32'(cnt), 32'd2);

    // Execute stall holds off acceptance
    e_in = '0;
    e_in.valid = 1'b1;
    e_in.rd_ind = 5'd3;
    e_in.reg_dat = 32'h0000_CAFE;
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_no_we", {31'b0, rf_we}, 32'd0);
    end
    stall_in = 1'b0;
    sb_q.push_back({5'd3, 32'h0000_CAFE});
    step();
    e_in = '0;
    chk("stall_release_we", {31'b0, rf_we}, 32'd1);
    step();

    // Reset while a load is pending
    e_in.valid = 1'b1;
    e_in.ld_en = 1'b1;
    e_in.rd_ind = 5'd4;
    e_in.ld_spec = LD_LW;
    step();
    e_in = '0;
    chk("rstld_stall_pre", {31'b0, stall_out}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstld_stall_async", {31'b0, stall_out}, 32'd0);
    step();
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdat = 32'h4444_4444;
    step();
    mem_rvalid = 1'b0;
    chk("rstld_stall_post", {31'b0, stall_out}, 32'd0);
    chk("rstld_no_we", {31'b0, rf_we}, 32'd0);
    step();
    chk("rstld_no_we2", {31'b0, rf_we}, 32'd0);

    // Long load wait: timeout or indefinite hold depending on build
    e_in.valid = 1'b1;
    e_in.ld_en = 1'b1;
    e_in.rd_ind = 5'd6;
    e_in.ld_spec = LD_LW;
    step();
    e_in = '0;
`ifdef WB_LD_TIMEOUT_EN
    for (int i = 1; i < 16; i++) step();
    chk("tmo_err_early", {31'b0, ld_err}, 32'd0);
    chk("tmo_stall_early", {31'b0, stall_out}, 32'd1);
    step();
    chk("tmo_err_set", {31'b0, ld_err}, 32'd1);
    chk("tmo_stall_clr", {31'b0, stall_out}, 32'd0);
    chk("tmo_no_we", {31'b0, rf_we}, 32'd0);
    drive_alu(5'd2, 32'h0000_0022);
    chk("tmo_idle_accept", {31'b0, rf_we}, 32'd1);
    chk("tmo_err_sticky", {31'b0, ld_err}, 32'd1);
`else
    for (int i = 0; i < 40; i++) step();
    chk("noto_stall_hold", {31'b0, stall_out}, 32'd1);
    chk("noto_ld_err", {31'b0, ld_err}, 32'd0);
    sb_q.push_back({5'd6, 32'h6666_0006});
    mem_rvalid = 1'b1;
    mem_rdat = 32'h6666_0006;
    step();
    mem_rvalid = 1'b0;
    chk("noto_we", {31'b0, rf_we}, 32'd1);
    chk("noto_stall_clr", {31'b0, stall_out}, 32'd0);
`endif

    step();
    step();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
